// File: rtl/atom_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// atom_wb_arb_pkg : shared types and constants for the IBUS/DBUS arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package atom_wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   localparam logic       GNT_IBUS = 1'b0;
   localparam logic       GNT_DBUS = 1'b1;

   localparam logic [3:0] SEL_ALL  = 4'hF;
   localparam logic       WE_READ  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/atom_wb_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog : saturating per-transaction cycle counter with expiry flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
         localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
         assign o_expired = (cnt_q == LIMIT);
      end else begin : g_wdog_off
         assign o_expired = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/atom_wb_arbiter.sv
// ---------------------------------------------------------------------------
// atom_wb_arbiter : round-robin IBUS/DBUS merge onto one Wishbone master port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module atom_wb_arbiter
   import atom_wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [31:0] ibus_adr_i,
   input  logic        ibus_stb_i,
   output logic [31:0] ibus_dat_o,
   output logic        ibus_ack_o,
   output logic        ibus_err_o,
   input  logic [31:0] dbus_adr_i,
   input  logic [31:0] dbus_dat_i,
   input  logic        dbus_we_i,
   input  logic [3:0]  dbus_sel_i,
   input  logic        dbus_stb_i,
   input  logic        dbus_cyc_i,
   output logic [31:0] dbus_dat_o,
   output logic        dbus_ack_o,
   output logic        dbus_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic        s_ack_i
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       ibus_req, dbus_req, gnt_i, gnt_d, req_g;
   logic       expired, timeout, pick_d;

   assign ibus_req = ibus_stb_i;
   assign dbus_req = dbus_stb_i & dbus_cyc_i;
   assign gnt_i    = (state_q == GNT_I);
   assign gnt_d    = (state_q == GNT_D);
   assign req_g    = (gnt_i & ibus_req) | (gnt_d & dbus_req);
   // An ack arriving in the expiry cycle completes the transfer instead
   assign timeout  = expired & req_g & ~s_ack_i;

   wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .i_clear  (state_q == IDLE),
      .i_enable (state_q != IDLE),
      .o_expired(expired)
   );

   assign s_stb_o    = req_g & ~timeout;
   assign s_cyc_o    = s_stb_o;
   assign s_adr_o    = gnt_i ? ibus_adr_i : (gnt_d ? dbus_adr_i : 32'h0);
   assign s_dat_o    = gnt_d ? dbus_dat_i : 32'h0;
   assign s_we_o     = gnt_d ? dbus_we_i  : WE_READ;
   assign s_sel_o    = gnt_i ? SEL_ALL    : (gnt_d ? dbus_sel_i : 4'h0);

   assign ibus_dat_o = s_dat_i;
   assign dbus_dat_o = s_dat_i;
   assign ibus_ack_o = gnt_i & ibus_req & s_ack_i;
   assign dbus_ack_o = gnt_d & dbus_req & s_ack_i;
   assign ibus_err_o = gnt_i & timeout;
   assign dbus_err_o = gnt_d & timeout;

   // On a tie the master that did not win last time goes first
   assign pick_d = dbus_req & (~ibus_req | (last_grant_q == GNT_IBUS));

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (ibus_req || dbus_req) begin
               state_d      = pick_d ? GNT_D : GNT_I;
               last_grant_d = pick_d ? GNT_DBUS : GNT_IBUS;
            end
         end
         GNT_I, GNT_D: begin
            if (s_ack_i || !req_g || timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_IBUS;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_atom_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_atom_wb_arbiter : directed + randomized bench for atom_wb_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_atom_wb_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ibus_adr, dbus_adr, dbus_dat, s_dat_i;
   logic        ibus_stb, dbus_we, dbus_stb, dbus_cyc, s_ack_i;
   logic [3:0]  dbus_sel;
   logic [31:0] ibus_dat_o, dbus_dat_o, s_adr_o, s_dat_o;
   logic        ibus_ack_o, ibus_err_o, dbus_ack_o, dbus_err_o;
   logic        s_we_o, s_stb_o, s_cyc_o;
   logic [3:0]  s_sel_o;

   int   n_pass  = 0;
   int   n_total = 0;
   logic last_w;   // 0 = IBUS won last, 1 = DBUS won last

   always #5 clk = ~clk;

   atom_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .ibus_adr_i(ibus_adr),
      .ibus_stb_i(ibus_stb),
      .ibus_dat_o(ibus_dat_o),
      .ibus_ack_o(ibus_ack_o),
      .ibus_err_o(ibus_err_o),
      .dbus_adr_i(dbus_adr),
      .dbus_dat_i(dbus_dat),
      .dbus_we_i (dbus_we),
      .dbus_sel_i(dbus_sel),
      .dbus_stb_i(dbus_stb),
      .dbus_cyc_i(dbus_cyc),
      .dbus_dat_o(dbus_dat_o),
      .dbus_ack_o(dbus_ack_o),
      .dbus_err_o(dbus_err_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_dat_i   (s_dat_i),
      .s_we_o    (s_we_o),
      .s_sel_o   (s_sel_o),
      .s_stb_o   (s_stb_o),
      .s_cyc_o   (s_cyc_o),
      .s_ack_i   (s_ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_stb"},  s_stb_o,    0);
      chk({tag, "_iack"}, ibus_ack_o, 0);
      chk({tag, "_dack"}, dbus_ack_o, 0);
      chk({tag, "_ierr"}, ibus_err_o, 0);
      chk({tag, "_derr"}, dbus_err_o, 0);
   endtask

   // One whole transaction from the slave's point of view: the slave acks
   // 'lat' cycles after strobe, or never when lat >= TO (watchdog fires).
   // Called while the arbiter is idle with requests already raised.
   task automatic serve(input int lat, input bit keep, input logic [31:0] rd);
      logic d_req, w;
      bit   to, done;
      int   k;
      d_req  = dbus_stb && dbus_cyc;
      w      = (ibus_stb && d_req) ? ~last_w : d_req;
      last_w = w;
      k      = 0;
      done   = 0;
      while (!done) begin
         @(negedge clk);
         s_ack_i = (k == lat);
         s_dat_i = rd;
         #1;
         to = (k == TO - 1) && (lat > k);
         chk("stb",  s_stb_o, !to);
         chk("cyc",  s_cyc_o, !to);
         chk("adr",  s_adr_o, w ? dbus_adr : ibus_adr);
         chk("we",   s_we_o,  w ? dbus_we : 1'b0);
         chk("sel",  s_sel_o, w ? dbus_sel : 4'hF);
         chk("wdat", s_dat_o, w ? dbus_dat : 32'h0);
         chk("iack", ibus_ack_o, !w && s_ack_i);
         chk("dack", dbus_ack_o, w && s_ack_i);
         chk("ierr", ibus_err_o, !w && to);
         chk("derr", dbus_err_o, w && to);
         chk("idat", ibus_dat_o, rd);
         chk("ddat", dbus_dat_o, rd);
         done = s_ack_i || to;
         k++;
      end
      @(negedge clk);
      s_ack_i = 1'b0;
      if (!keep) begin
         if (w) dbus_stb = 1'b0;
         else   ibus_stb = 1'b0;
      end else begin
         if (w) dbus_adr = 32'h2000_0000 | $urandom_range(0, 16'hFFFF);
         else   ibus_adr = 32'h1000_0000 | $urandom_range(0, 16'hFFFF);
      end
      #1;
      chk_quiet("gap");
      chk("gap_adr", s_adr_o, 32'h0);
   endtask

   initial begin
      int m;
      rst_n = 1'b0; last_w = 1'b0;
      ibus_adr = '0; ibus_stb = 0; dbus_adr = '0; dbus_dat = '0; dbus_we = 0;
      dbus_sel = '0; dbus_stb = 0; dbus_cyc = 0; s_dat_i = '0; s_ack_i = 0;

      // Reset with random inputs: everything quiet, read data passes through
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ibus_adr = $urandom; ibus_stb = 1; dbus_adr = $urandom; dbus_dat = $urandom;
         dbus_we = 1; dbus_sel = 4'($urandom); dbus_stb = 1; dbus_cyc = 1;
         s_dat_i = $urandom; s_ack_i = 1;
         #1;
         chk_quiet("rst");
         chk("rst_cyc",  s_cyc_o, 0);
         chk("rst_we",   s_we_o,  0);
         chk("rst_sel",  s_sel_o, 0);
         chk("rst_adr",  s_adr_o, 0);
         chk("rst_wdat", s_dat_o, 0);
         chk("rst_idat", ibus_dat_o, s_dat_i);
         chk("rst_ddat", dbus_dat_o, s_dat_i);
      end
      @(negedge clk);
      ibus_stb = 0; dbus_stb = 0; s_ack_i = 0; rst_n = 1;

      // Strobe without cycle is not a request
      dbus_stb = 1; dbus_cyc = 0;
      repeat (2) begin
         @(negedge clk); #1;
         chk("nocyc_stb", s_stb_o, 0);
      end
      @(negedge clk);
      dbus_stb = 0; dbus_cyc = 1;

      // First tie goes to DBUS; DBUS write passes through unchanged
      @(negedge clk);
      ibus_adr = 32'h0000_1000; ibus_stb = 1;
      dbus_adr = 32'h0000_0100; dbus_dat = 32'h1234_5678; dbus_sel = 4'b0011;
      dbus_we = 1; dbus_stb = 1;
      serve(0, 0, $urandom);
      serve(0, 0, $urandom);

      // Single IBUS read, ack two cycles after strobe
      @(negedge clk);
      ibus_adr = 32'h0000_2000; ibus_stb = 1;
      serve(2, 0, 32'hDEADBEEF);

      // DBUS timeout with IBUS pending, then ack in the last watchdog cycle
      @(negedge clk);
      ibus_adr = 32'h0000_3000; ibus_stb = 1;
      dbus_adr = 32'h0000_0200; dbus_we = 0; dbus_sel = 4'hC; dbus_stb = 1;
      serve(9, 0, $urandom);
      serve(1, 0, $urandom);
      @(negedge clk);
      dbus_stb = 1;
      serve(TO - 1, 0, $urandom);

      // DBUS abort, late ack ignored, next request served normally
      @(negedge clk);
      dbus_adr = 32'h0000_0300; dbus_stb = 1;
      @(negedge clk); #1;
      chk("abort_gnt", s_stb_o, 1);
      @(negedge clk);
      dbus_stb = 0; #1;
      chk_quiet("abort_drop");
      @(negedge clk);
      s_ack_i = 1; #1;
      chk_quiet("late_ack");
      @(negedge clk);
      s_ack_i = 0; last_w = 1'b1;
      ibus_adr = 32'h0000_4000; ibus_stb = 1;
      serve(1, 0, $urandom);

      // Both masters continuously requesting, zero-wait slave
      @(negedge clk);
      ibus_adr = 32'h1000_0000; dbus_adr = 32'h2000_0000;
      ibus_stb = 1; dbus_stb = 1;
      for (int t = 0; t < 100; t++) serve(0, 1, $urandom);
      ibus_stb = 0; dbus_stb = 0;

      // Random traffic with random slave latency
      for (int r = 0; r < 40; r++) begin
         @(negedge clk);
         m = $urandom_range(1, 3);
         ibus_adr = $urandom; dbus_adr = $urandom; dbus_dat = $urandom;
         dbus_we = 1'($urandom_range(0, 1)); dbus_sel = 4'($urandom_range(0, 15));
         ibus_stb = m[0]; dbus_stb = m[1];
         while (ibus_stb || (dbus_stb && dbus_cyc)) serve($urandom_range(0, 5), 0, $urandom);
      end

      // Reset mid-transaction: strobe drops at once, arbitration restarts
      @(negedge clk);
      ibus_adr = 32'h0000_5000; ibus_stb = 1;
      @(negedge clk); #1;
      chk("mid_gnt", s_stb_o, 1);
      #1; rst_n = 0; s_ack_i = 1; #1;
      chk_quiet("mid_rst");
      @(negedge clk);
      rst_n = 1; s_ack_i = 0; last_w = 1'b0;
      dbus_adr = 32'h0000_0400; dbus_stb = 1;
      serve(0, 0, $urandom);
      serve(0, 0, $urandom);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
